// File: rtl/lib_cpu.sv
// Shared CPU-side definitions used by the interrupt arbiter.
package lib_cpu;
  typedef enum logic [1:0] {IA_IDLE, IA_PRESENT, IA_RELEASE} IA_STATE;
  localparam int IA_ID_W = 3;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of pending at or above rr_ptr, wrapping modulo N_SRC.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             vld,
  output logic [ID_W-1:0]  idx
);
  // Walk the offsets from farthest to nearest so the nearest pending source wins.
  always_comb begin
    vld = |pending;
    idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % N_SRC]) idx = ID_W'((int'(rr_ptr) + k) % N_SRC);
    end
  end
endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: latches source events, presents one at a time to the CPU and
// holds it until acknowledged, then re-arbitrates round-robin.
module intr_arbiter
  import lib_cpu::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = IA_ID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_pulse,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_done,
  output logic [N_SRC-1:0]        src_ovf,
  input  logic [N_SRC-1:0]        ovf_clr,
  input  logic                    intr_en,
  input  logic                    cpu_ack,
  output logic                    irr,
  output logic [ID_W-1:0]         irq_id,
  output logic [DATA_W-1:0]       irq_data
);
  IA_STATE                      state, state_n;
  logic [N_SRC-1:0]             pending, clr_mask;
  logic [N_SRC-1:0][DATA_W-1:0] data_q;
  logic [ID_W-1:0]              sel, sel_inc, rr_ptr, pick_idx;
  logic [DATA_W-1:0]            pick_data;
  logic                         pick_vld, do_sel, do_ack;

  rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .vld     (pick_vld),
    .idx     (pick_idx)
  );

  always_comb begin
    state_n = state;
    do_sel  = 1'b0;
    do_ack  = 1'b0;
    case (state)
      IA_IDLE:    if (intr_en && pick_vld) begin do_sel = 1'b1; state_n = IA_PRESENT; end
      IA_PRESENT: if (cpu_ack) begin do_ack = 1'b1; state_n = IA_RELEASE; end
      IA_RELEASE: state_n = IA_IDLE;
      default:    state_n = IA_IDLE;
    endcase
  end

  always_comb begin
    pick_data = '0;
    clr_mask  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pick_idx == ID_W'(i)) pick_data = data_q[i];
      clr_mask[i] = do_ack && (sel == ID_W'(i));
    end
  end

  assign sel_inc = (sel == ID_W'(N_SRC - 1)) ? '0 : sel + 1'b1;

  // Clearing the acked source beats a same-cycle pulse on it; that pulse only raises ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IA_IDLE;
      pending  <= '0;
      data_q   <= '0;
      src_ovf  <= '0;
      src_done <= '0;
      rr_ptr   <= '0;
      sel      <= '0;
      irr      <= 1'b0;
      irq_id   <= '0;
      irq_data <= '0;
    end else begin
      state    <= state_n;
      pending  <= (pending | src_pulse) & ~clr_mask;
      src_ovf  <= (src_ovf & ~ovf_clr) | (src_pulse & pending);
      src_done <= clr_mask;
      for (int i = 0; i < N_SRC; i++)
        if (src_pulse[i] && !pending[i]) data_q[i] <= src_data[i*DATA_W +: DATA_W];
      if (do_sel) begin
        sel      <= pick_idx;
        irr      <= 1'b1;
        irq_id   <= pick_idx;
        irq_data <= pick_data;
      end else if (do_ack) begin
        irr      <= 1'b0;
        irq_id   <= '0;
        irq_data <= '0;
        rr_ptr   <= sel_inc;
      end
    end
  end
endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_intr_arbiter;
  logic        clk, rst;
  logic [3:0]  src_pulse, src_done, src_ovf, ovf_clr;
  logic [31:0] src_data;
  logic        intr_en, cpu_ack, irr;
  logic [2:0]  irq_id;
  logic [7:0]  irq_data;
  int          checks, errors;

  // reference model state: phase 0=waiting, 1=presenting, 2=release gap
  bit          m_pend[4];
  logic [7:0]  m_data[4];
  bit   [3:0]  m_ovf, m_done;
  int          m_ptr, m_sel, m_phase;

  intr_arbiter #(.N_SRC(4), .DATA_W(8), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .src_pulse(src_pulse), .src_data(src_data),
    .src_done(src_done), .src_ovf(src_ovf), .ovf_clr(ovf_clr),
    .intr_en(intr_en), .cpu_ack(cpu_ack), .irr(irr), .irq_id(irq_id), .irq_data(irq_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_data[i] = 8'h00; end
    m_ovf = '0; m_done = '0; m_ptr = 0; m_sel = 0; m_phase = 0;
  endtask

  task automatic model_step();
    int nphase, clr;
    bit [3:0] done_n;
    nphase = m_phase; clr = -1; done_n = '0;
    if (m_phase == 0) begin
      if (intr_en) begin
        for (int k = 0; k < 4; k++) begin
          if (nphase == 0 && m_pend[(m_ptr + k) % 4]) begin m_sel = (m_ptr + k) % 4; nphase = 1; end
        end
      end
    end else if (m_phase == 1) begin
      if (cpu_ack) begin clr = m_sel; done_n[m_sel] = 1'b1; m_ptr = (m_sel + 1) % 4; nphase = 2; end
    end else nphase = 0;
    for (int i = 0; i < 4; i++) begin
      m_ovf[i] = (m_ovf[i] & !ovf_clr[i]) | (src_pulse[i] & m_pend[i]);
      if (src_pulse[i] && !m_pend[i]) begin m_pend[i] = 1; m_data[i] = src_data[i*8 +: 8]; end
    end
    if (clr >= 0) m_pend[clr] = 0;
    m_done = done_n; m_phase = nphase;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    src_pulse = '0; cpu_ack = 1'b0; ovf_clr = '0;
  endtask

  task automatic pulse(input int i, input logic [7:0] v);
    src_pulse[i] = 1'b1;
    src_data[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++; if (irr !== 1'b0 || irq_id !== 3'd0 || irq_data !== 8'h00) begin errors++;
      $display("FAIL reset_irq got irr=%0d id=%0d data=%0h exp 0 0 0", irr, irq_id, irq_data); end
    checks++; if (src_done !== 4'b0 || src_ovf !== 4'b0) begin errors++;
      $display("FAIL reset_flags got done=%b ovf=%b exp 0000 0000", src_done, src_ovf); end
    tick(); rst = 1'b0;
  endtask

  task automatic test_basic();
    intr_en = 1'b1; pulse(0, 8'h41); tick();
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL basic_capture got irr=%0d exp 0", irr); end
    tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd0 || irq_data !== 8'h41) begin errors++;
      $display("FAIL basic_present got irr=%0d id=%0d data=%0h exp 1 0 41", irr, irq_id, irq_data); end
    cpu_ack = 1'b1; tick();
    checks++; if (src_done !== 4'b0001 || irr !== 1'b0 || irq_data !== 8'h00) begin errors++;
      $display("FAIL basic_ack got done=%b irr=%0d data=%0h exp 0001 0 0", src_done, irr, irq_data); end
    tick();
    checks++; if (src_done !== 4'b0000 || irr !== 1'b0) begin errors++;
      $display("FAIL basic_after got done=%b irr=%0d exp 0000 0", src_done, irr); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    intr_en = 1'b1; pulse(1, 8'h11); pulse(3, 8'h33); tick(); tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd1 || irq_data !== 8'h11) begin errors++;
      $display("FAIL rr_first got irr=%0d id=%0d data=%0h exp 1 1 11", irr, irq_id, irq_data); end
    cpu_ack = 1'b1; tick();
    checks++; if (src_done !== 4'b0010 || irr !== 1'b0) begin errors++;
      $display("FAIL rr_done1 got done=%b irr=%0d exp 0010 0", src_done, irr); end
    tick(); tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd3 || irq_data !== 8'h33) begin errors++;
      $display("FAIL rr_second got irr=%0d id=%0d data=%0h exp 1 3 33", irr, irq_id, irq_data); end
    cpu_ack = 1'b1; tick();
    checks++; if (src_done !== 4'b1000) begin errors++; $display("FAIL rr_done3 got %b exp 1000", src_done); end
    pulse(1, 8'h55); tick(); tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd1 || irq_data !== 8'h55) begin errors++;
      $display("FAIL rr_ptr_setup got irr=%0d id=%0d data=%0h exp 1 1 55", irr, irq_id, irq_data); end
    cpu_ack = 1'b1; tick();
    pulse(0, 8'h0A); pulse(1, 8'h1B); tick(); tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd0 || irq_data !== 8'h0A) begin errors++;
      $display("FAIL rr_wrap_first got irr=%0d id=%0d data=%0h exp 1 0 0a", irr, irq_id, irq_data); end
    cpu_ack = 1'b1; tick(); tick(); tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd1 || irq_data !== 8'h1B) begin errors++;
      $display("FAIL rr_wrap_second got irr=%0d id=%0d data=%0h exp 1 1 1b", irr, irq_id, irq_data); end
    cpu_ack = 1'b1; tick(); tick();
  endtask

  task automatic test_intr_en();
    intr_en = 1'b0; pulse(2, 8'h22); tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (irr !== 1'b0) begin errors++; $display("FAIL en_masked cyc %0d got irr=%0d exp 0", c, irr); end
    end
    intr_en = 1'b1; tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd2 || irq_data !== 8'h22) begin errors++;
      $display("FAIL en_raise got irr=%0d id=%0d data=%0h exp 1 2 22", irr, irq_id, irq_data); end
    intr_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (irr !== 1'b1 || irq_id !== 3'd2) begin errors++;
        $display("FAIL en_hold cyc %0d got irr=%0d id=%0d exp 1 2", c, irr, irq_id); end
    end
    cpu_ack = 1'b1; tick();
    checks++; if (src_done !== 4'b0100 || irr !== 1'b0) begin errors++;
      $display("FAIL en_ack got done=%b irr=%0d exp 0100 0", src_done, irr); end
    tick();
  endtask

  task automatic test_overflow();
    intr_en = 1'b1; pulse(0, 8'hAA); tick();
    pulse(0, 8'hBB); tick();
    checks++; if (irr !== 1'b1 || irq_id !== 3'd0 || irq_data !== 8'hAA || src_ovf !== 4'b0001) begin errors++;
      $display("FAIL ovf_first_wins got irr=%0d id=%0d data=%0h ovf=%b exp 1 0 aa 0001", irr, irq_id, irq_data, src_ovf); end
    tick();
    checks++; if (src_ovf !== 4'b0001) begin errors++; $display("FAIL ovf_sticky got %b exp 0001", src_ovf); end
    ovf_clr = 4'b0001; tick();
    checks++; if (src_ovf !== 4'b0000 || irq_data !== 8'hAA) begin errors++;
      $display("FAIL ovf_clear got ovf=%b data=%0h exp 0000 aa", src_ovf, irq_data); end
    cpu_ack = 1'b1; pulse(0, 8'hDD); ovf_clr = 4'b0001; tick();
    checks++; if (src_done !== 4'b0001 || src_ovf !== 4'b0001 || irr !== 1'b0) begin errors++;
      $display("FAIL ovf_ack_collide got done=%b ovf=%b irr=%0d exp 0001 0001 0", src_done, src_ovf, irr); end
    tick(); tick();
    checks++; if (irr !== 1'b0) begin errors++; $display("FAIL ovf_dropped got irr=%0d exp 0", irr); end
    ovf_clr = 4'b1111; tick();
  endtask

  task automatic test_reset_mid();
    intr_en = 1'b1; pulse(1, 8'h77); pulse(2, 8'h88); tick(); tick();
    checks++; if (irr !== 1'b1) begin errors++; $display("FAIL midrst_setup got irr=%0d exp 1", irr); end
    #2 rst = 1'b1; #1;
    checks++; if (irr !== 1'b0 || irq_id !== 3'd0 || irq_data !== 8'h00) begin errors++;
      $display("FAIL midrst_async got irr=%0d id=%0d data=%0h exp 0 0 0", irr, irq_id, irq_data); end
    tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (irr !== 1'b0 || src_done !== 4'b0000) begin errors++;
        $display("FAIL midrst_quiet cyc %0d got irr=%0d done=%b exp 0 0000", c, irr, src_done); end
    end
  endtask

  task automatic test_random();
    logic [2:0] e_id;
    logic [7:0] e_data;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      intr_en = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) pulse(i, 8'($urandom));
      cpu_ack = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      tick();
      e_id = (m_phase == 1) ? 3'(m_sel) : 3'd0;
      e_data = (m_phase == 1) ? m_data[m_sel] : 8'h00;
      checks++; if (irr !== (m_phase == 1) || irq_id !== e_id || irq_data !== e_data) begin errors++;
        $display("FAIL rand_irq cyc %0d got irr=%0d id=%0d data=%0h exp %0d %0d %0h", c, irr, irq_id, irq_data, m_phase == 1, e_id, e_data); end
      checks++; if (src_done !== m_done || src_ovf !== m_ovf) begin errors++;
        $display("FAIL rand_flags cyc %0d got done=%b ovf=%b exp %b %b", c, src_done, src_ovf, m_done, m_ovf); end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; src_pulse = '0; src_data = '0; ovf_clr = '0; intr_en = 1'b0; cpu_ack = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_intr_en();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
